hd44780_ctrl: RTL and testbench
===============================

// Module: hd44780_ctrl
// PURPOSE
//  Hardware HD44780 LCD bus engine replacing software bit-banging of RS/E/DATA
//  through the GPMC register bank. Host writes {nib,rs,byte} words into a command
//  FIFO; the block generates RS/E/DATA with programmable setup, E-pulse, hold and
//  execution-wait timing, in 8-bit or 4-bit bus mode. Sits between the GPMC
//  register bank (write side) and the LCD pins.
// PARAMETERS
//  FIFO_DEPTH  16     command FIFO entries, power of two, >=2
//  BUS_4BIT    0      1: 4-bit bus, byte sent high nibble then low nibble on data[7:4]
//  T_SETUP     2      clk cycles RS/DATA stable before E rises (>=1)
//  T_EPW       24     clk cycles E high (>=1)
//  T_HOLD      2      clk cycles RS/DATA held after E falls (>=1)
//  T_EXEC      2000   clk cycles wait after a normal command/data transfer (>=1)
//  T_EXEC_LONG 80000  clk cycles wait after clear/home (rs=0, byte 0x01..0x03)
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  wr_en     in   1   push wr_data into FIFO (ignored when full)
//  wr_data   in   10  [7:0] byte, [8] rs, [9] nib: 4-bit mode send high nibble only
//  full      out  1   FIFO full (count==FIFO_DEPTH)
//  level     out  clog2(FIFO_DEPTH)+1  FIFO occupancy
//  busy      out  1   FIFO non-empty or FSM not IDLE
//  ovf       out  1   sticky: write attempted while full
//  ovf_clr   in   1   clears ovf (set wins over clear on same cycle)
//  rs        out  1   LCD register select
//  e         out  1   LCD enable strobe
//  rw        out  1   LCD read/write, constant 0 (write-only)
//  data      out  8   LCD data bus; 4-bit mode: nibble on [7:4], [3:0]=0
// BEHAVIOUR
//  Reset: FIFO empty, level=0, full=0, busy=0, ovf=0, rs=0, e=0, rw=0, data=0, FSM IDLE.
//  Reset mid-transfer: e drops to 0 asynchronously; FIFO contents discarded.
//  FIFO: full/level from registered count; write while full dropped and sets ovf
//  even if a pop occurs same cycle. Simultaneous push+pop when not full: level unchanged.
//  FSM states IDLE, SETUP, EHIGH, HOLD, WAIT; one down-counter sized for T_EXEC_LONG.
//  IDLE: if FIFO non-empty, pop head (cycle N); cycle N+1 enter SETUP driving rs and
//   data (8-bit: byte; 4-bit: byte[7:4]).
//  SETUP T_SETUP cycles, e=0 -> EHIGH T_EPW cycles, e=1 -> HOLD T_HOLD cycles, e=0.
//  rs/data constant from SETUP entry to HOLD exit.
//  After HOLD: 4-bit mode, nib=0, first nibble done -> SETUP with byte[3:0] on data[7:4];
//   otherwise -> WAIT. No execution wait between nibbles of one byte.
//  WAIT: T_EXEC_LONG cycles if rs=0 and byte in {0x01,0x02,0x03}, else T_EXEC; e=0,
//   rs/data keep last value; then IDLE. nib ignored when BUS_4BIT=0.
//  Back-to-back: next pop on the IDLE cycle after WAIT expires; FIFO may refill anytime.
//  busy deasserts the cycle after WAIT->IDLE when FIFO empty.
// TESTING (T_SETUP=2,T_EPW=4,T_HOLD=2,T_EXEC=10,T_EXEC_LONG=50,FIFO_DEPTH=4)
//  8-bit, push 0x141 (rs=1,'A') -> rs=1,data=0x41 2 cyc, e=1 exactly 4 cyc, held 2 cyc,
//   busy total 1+2+4+2+10 cycles incl. pop, rw=0 throughout.
//  8-bit, push 0x001 (clear) -> one e pulse, next command's e rises >=50 cyc after e fall.
//  BUS_4BIT=1, push 0x128 -> data=0x20 then 0x80, two 4-cyc e pulses, single wait of 10.
//  BUS_4BIT=1, push 0x230 (nib=1) -> one e pulse with data=0x30, then wait 10.
//  Push 6 words while FSM busy -> 4 accepted, full=1, ovf=1; ovf_clr clears; 4 bytes
//   emitted in order.
//  Assert rst_n low while e=1 -> e=0, level=0, busy=0 immediately; no further pulses.

Source files
------------

// File: rtl/hd44780_ctrl.sv
// hd44780_ctrl
//   Hardware HD44780 LCD bus engine. Host words {nib,rs,byte} are queued in a
//   command FIFO and replayed on the LCD pins with programmable setup, E-pulse,
//   hold and execution-wait timing, in 8-bit or 4-bit bus mode.
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_data     push strobe and word: [7:0] byte, [8] rs, [9] nib
//   full, level        FIFO full flag and occupancy (registered count)
//   busy               FIFO non-empty or engine not idle
//   ovf, ovf_clr       sticky overflow flag and its clear (set wins)
//   rs, e, rw, data    LCD pins (rw tied low, write-only bus)
//   dbg_state          current engine state, for observation only
// Handshake: wr_en is a one-cycle push strobe with no ready; full is the
//   not-ready indication. A word is accepted on a clk edge where wr_en=1 and
//   full=0; a push while full is dropped and sets ovf.
module hd44780_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int BUS_4BIT    = 0,
  parameter int T_SETUP     = 2,
  parameter int T_EPW       = 24,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 80000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [9:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          rs,
  output logic                          e,
  output logic                          rw,
  output logic [7:0]                    data,
  output logic [2:0]                    dbg_state
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TM1  = (T_EXEC_LONG > T_EXEC) ? T_EXEC_LONG : T_EXEC;
  localparam int TM2  = (T_EPW > T_SETUP) ? T_EPW : T_SETUP;
  localparam int TM3  = (TM2 > T_HOLD) ? TM2 : T_HOLD;
  localparam int TMAX = (TM1 > TM3) ? TM1 : TM3;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EPW   = CW'(T_EPW - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_LONG  = CW'(T_EXEC_LONG - 1);
  localparam logic [AW:0]   C_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EHIGH = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // ---------------- command FIFO ----------------
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full, w_push, w_pop;
  logic [9:0]    w_head;

  assign w_full = (r_count == C_FULL);
  assign w_push = wr_en && !w_full;
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A dropped push sets ovf even when a pop frees a slot this cycle,
      // because full is taken from the registered count.
      if (wr_en && w_full) r_ovf <= 1'b1;
      else if (ovf_clr)    r_ovf <= 1'b0;
    end
  end

  // ---------------- bus engine ----------------
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_rs, r_nib, r_long, r_second;
  logic [3:0]    r_lo;
  logic [7:0]    r_data;
  logic          w_nib2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rs     <= 1'b0;
      r_data   <= '0;
      r_lo     <= '0;
      r_nib    <= 1'b0;
      r_long   <= 1'b0;
      r_second <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) begin
        r_rs     <= w_head[8];
        r_lo     <= w_head[3:0];
        r_nib    <= w_head[9];
        r_long   <= !w_head[8] && (w_head[7:0] >= 8'h01) && (w_head[7:0] <= 8'h03);
        r_second <= 1'b0;
        r_data   <= (BUS_4BIT != 0) ? {w_head[7:4], 4'h0} : w_head[7:0];
      end else if (w_nib2) begin
        r_second <= 1'b1;
        r_data   <= {r_lo, 4'h0};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_nib2      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = C_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_EHIGH;
          w_cnt_nxt   = C_EPW;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_EHIGH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = C_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          // Low nibble follows directly, with no execution wait in between.
          if ((BUS_4BIT != 0) && !r_nib && !r_second) begin
            w_nib2      = 1'b1;
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = C_SETUP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = r_long ? C_LONG : C_EXEC;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign full      = w_full;
  assign level     = r_count;
  assign busy      = (r_count != '0) || (r_state != S_IDLE);
  assign ovf       = r_ovf;
  assign rs        = r_rs;
  assign e         = (r_state == S_EHIGH);
  assign rw        = 1'b0;
  assign data      = r_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb_hd44780_ctrl
//   Bench for hd44780_ctrl: an 8-bit instance (index 0) and a 4-bit instance
//   (index 1) with short timing. A model expands every accepted word into the
//   list of E pulses (rs, data, required gap to the next pulse) it must cause;
//   a monitor compares observed pulses with that list.
module tb_hd44780_ctrl;

  localparam int TS = 2, TE = 4, TH = 2, TX = 10, TL = 50, D = 4;

  typedef struct packed {
    logic        rs;
    logic [7:0]  d;
    logic [15:0] gap;
    logic        exact;
  } pulse_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en [2];
  logic [9:0] wr_data [2];
  logic       ovf_clr [2];
  logic       full [2], busy [2], ovf [2], rs [2], e [2], rw [2];
  logic [2:0] level [2];
  logic [7:0] data [2];
  logic [2:0] dbg [2];

  hd44780_ctrl #(.FIFO_DEPTH(D), .BUS_4BIT(0), .T_SETUP(TS), .T_EPW(TE),
                 .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .full(full[0]), .level(level[0]), .busy(busy[0]), .ovf(ovf[0]),
    .ovf_clr(ovf_clr[0]), .rs(rs[0]), .e(e[0]), .rw(rw[0]), .data(data[0]),
    .dbg_state(dbg[0]));

  hd44780_ctrl #(.FIFO_DEPTH(D), .BUS_4BIT(1), .T_SETUP(TS), .T_EPW(TE),
                 .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .full(full[1]), .level(level[1]), .busy(busy[1]), .ovf(ovf[1]),
    .ovf_clr(ovf_clr[1]), .rs(rs[1]), .e(e[1]), .rw(rw[1]), .data(data[1]),
    .dbg_state(dbg[1]));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  pulse_t exp_q0[$];
  pulse_t exp_q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q_push(input int k, input pulse_t p);
    if (k == 0) exp_q0.push_back(p);
    else        exp_q1.push_back(p);
  endtask

  // Reference model: expected pulses of one accepted word.
  task automatic model_word(input int k, input logic [9:0] w);
    pulse_t p;
    int     wt;
    wt = (!w[8] && w[7:0] >= 8'h01 && w[7:0] <= 8'h03) ? TL : TX;
    p.rs = w[8];
    if (k == 1 && !w[9]) begin
      p.d = {w[7:4], 4'h0}; p.gap = 16'(TH + TS); p.exact = 1'b1;
      q_push(k, p);
      p.d = {w[3:0], 4'h0};
    end else if (k == 1) begin
      p.d = {w[7:4], 4'h0};
    end else begin
      p.d = w[7:0];
    end
    p.gap = 16'(TH + wt + 1 + TS); p.exact = 1'b0;
    q_push(k, p);
  endtask

  // ---------------- monitor ----------------
  int     cyc = 0;
  pulse_t cur [2];
  int     rise_c [2], fall_c [2], need_gap [2], gap_meas [2], npulse [2];
  bit     need_exact [2], in_p [2];
  int     rw_bad = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rise_c[k] = 0; fall_c[k] = 0; need_gap[k] = 0; gap_meas[k] = 0;
      npulse[k] = 0; need_exact[k] = 0; in_p[k] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        in_p[k] = 0; need_gap[k] = 0; need_exact[k] = 0;
      end else begin
        if (rw[k] !== 1'b0) rw_bad++;
        if (e[k] === 1'b1 && !in_p[k]) begin
          int qs;
          in_p[k] = 1; rise_c[k] = cyc; npulse[k]++;
          gap_meas[k] = cyc - fall_c[k];
          qs = (k == 0) ? exp_q0.size() : exp_q1.size();
          check("pulse_expected", 32'(qs > 0), 32'd1);
          if (qs > 0) begin
            cur[k] = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("pulse_rs", 32'(rs[k]), 32'(cur[k].rs));
            check("pulse_data", 32'(data[k]), 32'(cur[k].d));
            if (need_gap[k] > 0) begin
              if (need_exact[k]) check("gap_exact", 32'(gap_meas[k]), 32'(need_gap[k]));
              else check("gap_min", 32'(gap_meas[k] >= need_gap[k]), 32'd1);
            end
          end
        end else if (e[k] === 1'b0 && in_p[k]) begin
          in_p[k] = 0; fall_c[k] = cyc;
          check("e_width", 32'(cyc - rise_c[k]), 32'(TE));
          check("hold_rs", 32'(rs[k]), 32'(cur[k].rs));
          check("hold_data", 32'(data[k]), 32'(cur[k].d));
          need_gap[k] = int'(cur[k].gap); need_exact[k] = cur[k].exact;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input int k, input logic [9:0] w);
    @(posedge clk); #1;
    wr_en[k] = 1'b1; wr_data[k] = w;
    model_word(k, w);
    @(posedge clk); #1;
    wr_en[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy[k] === 1'b0) break;
    end
    check("idle_reached", 32'(busy[k]), 32'd0);
  endtask

  // Counts busy cycles, E-high cycles and setup cycles (rs/data valid before E).
  task automatic measure(input int k, input logic ers, input logic [7:0] edat,
                         output int nb, output int ne, output int nsu);
    bit seen;
    nb = 0; ne = 0; nsu = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy[k] === 1'b1) begin nb++; seen = 1; end
      if (e[k] === 1'b1) ne++;
      if (busy[k] === 1'b1 && e[k] === 1'b0 && ne == 0 && rs[k] === ers && data[k] === edat) nsu++;
      if (seen && busy[k] === 1'b0) break;
    end
    check("measure_done", 32'(busy[k]), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb, ne, nsu, n0, nw;
    logic [9:0] w;
    for (int k = 0; k < 2; k++) begin
      wr_en[k] = 1'b0; wr_data[k] = '0; ovf_clr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_level", 32'(level[k]), 32'd0);
      check("rst_full", 32'(full[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_ovf", 32'(ovf[k]), 32'd0);
      check("rst_pins", 32'({rs[k], e[k], rw[k], data[k]}), 32'd0);
    end
    rst_n = 1'b1;

    // 8-bit data write 'A'
    push_word(0, 10'h141);
    measure(0, 1'b1, 8'h41, nb, ne, nsu);
    check("a8_busy_cycles", 32'(nb), 32'(1 + TS + TE + TH + TX));
    check("a8_e_cycles", 32'(ne), 32'(TE));
    check("a8_setup_cycles", 32'(nsu), 32'(TS));

    // clear display followed directly by data: long wait in between
    push_word(0, 10'h001);
    push_word(0, 10'h141);
    wait_idle(0);
    check("clear_gap", 32'(gap_meas[0]), 32'(TH + TL + 1 + TS));

    // 4-bit: two nibbles, one wait
    push_word(1, 10'h128);
    measure(1, 1'b1, 8'h20, nb, ne, nsu);
    check("n4_busy_cycles", 32'(nb), 32'(1 + 2 * (TS + TE + TH) + TX));
    check("n4_e_cycles", 32'(ne), 32'(2 * TE));
    check("n4_nibble_gap", 32'(gap_meas[1]), 32'(TH + TS));

    // 4-bit nib=1: single high nibble
    push_word(1, 10'h230);
    measure(1, 1'b0, 8'h30, nb, ne, nsu);
    check("nib_busy_cycles", 32'(nb), 32'(1 + TS + TE + TH + TX));
    check("nib_e_cycles", 32'(ne), 32'(TE));

    // overflow while engine busy
    push_word(0, 10'h141);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      w = 10'h150 + 10'(i);
      wr_en[0] = 1'b1; wr_data[0] = w;
      if (i < D) model_word(0, w);
    end
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    check("ovf_level", 32'(level[0]), 32'(D));
    check("ovf_full", 32'(full[0]), 32'd1);
    check("ovf_set", 32'(ovf[0]), 32'd1);
    @(posedge clk); #1;
    wr_en[0] = 1'b1; ovf_clr[0] = 1'b1;
    @(posedge clk); #1;
    wr_en[0] = 1'b0; ovf_clr[0] = 1'b0;
    check("ovf_set_wins", 32'(ovf[0]), 32'd1);
    @(posedge clk); #1;
    ovf_clr[0] = 1'b1;
    @(posedge clk); #1;
    ovf_clr[0] = 1'b0;
    check("ovf_cleared", 32'(ovf[0]), 32'd0);
    check("ovf_level_kept", 32'(level[0]), 32'(D));
    wait_idle(0);
    check("ovf_drained", 32'(exp_q0.size()), 32'd0);

    // randomized bursts of up to three words on each instance
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 8; b++) begin
        nw = $urandom_range(1, 3);
        for (int i = 0; i < nw; i++) begin
          w[9] = 1'($urandom_range(0, 1));
          w[8] = 1'($urandom_range(0, 1));
          w[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                               : 8'($urandom_range(0, 255));
          @(posedge clk); #1;
          wr_en[k] = 1'b1; wr_data[k] = w;
          model_word(k, w);
        end
        @(posedge clk); #1;
        wr_en[k] = 1'b0;
        wait_idle(k);
      end
    end

    // reset while E is high
    push_word(0, 10'h141);
    push_word(0, 10'h142);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (e[0] === 1'b1) begin nb = 1; break; end
    end
    check("rst_e_seen", 32'(nb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_e", 32'(e[0]), 32'd0);
    check("rst_mid_level", 32'(level[0]), 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    exp_q0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = npulse[0];
    repeat (100) @(negedge clk);
    check("rst_no_pulses", 32'(npulse[0]), 32'(n0));
    check("rst_still_idle", 32'(busy[0]), 32'd0);

    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    check("rw_low", 32'(rw_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
